dm_lsu_initiator: RTL and testbench

//  CPU-side initiator for the data-memory port of the MEM block. Accepts byte/half/word

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 32 +++
 rtl/dm_lsu_initiator.sv | 126 ++++++++++++
 tb/tb_dm_lsu_initiator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and lane-select helpers for the DM load/store initiator.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } state_t;

  // Byte-lane enables touched by an access of the given size at a word offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_B:    return 4'b0001 << offset;
      SZ_H:    return offset[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] expand_mask(input logic [3:0] lanes);
    return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  endfunction

  // Copy right-aligned store data into every lane so the mask picks the target one.
  function automatic logic [31:0] replicate_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_B:    return {4{data[7:0]}};
      SZ_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] dout,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [31:0] shifted;
  logic [31:0] lane_bits;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old one.
  always_comb begin
    shifted    = dout >> {offset, 3'b000};
    lane_bits  = expand_mask(lane_mask(size, offset));
    merge_data = (dout & ~lane_bits) | (replicate_lanes(size, wdata) & lane_bits);
    case (size)
      SZ_B:    load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = dout;
    endcase
  end

endmodule

// File: rtl/dm_lsu_initiator.sv
// CPU-side initiator for the word-only data memory: byte/half/word loads and
// stores, read-modify-write for sub-word stores, error response for bad requests.
module dm_lsu_initiator
  import lsu_pkg::*;
#(
  parameter int DM_DEPTH  = 256,
  parameter bit CHECK_OOR = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] dm_addr,
  output logic        dm_we,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout
);

  state_t      state;
  logic        we_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic [1:0]  offset_r;
  logic [31:0] wdata_r;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        req_bad;

  always_comb begin
    req_bad = (req_size == 2'b11)
            || (req_size == SZ_H && req_addr[0])
            || (req_size == SZ_W && req_addr[1:0] != 2'b00)
            || (CHECK_OOR && ({2'b00, req_addr[31:2]} >= 32'(DM_DEPTH)));
  end

  lsu_align u_align (
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .offset      (offset_r),
    .dout        (dm_dout),
    .wdata       (wdata_r),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  // dm_addr and a word-store dm_we are set on the accept edge so they are
  // already valid throughout ACCESS; the merged sub-word word is registered
  // straight into dm_din on the way to WRITE.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset branch lets rstn kill dm_we immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      dm_addr    <= '0;
      dm_we      <= 1'b0;
      dm_din     <= '0;
      we_r       <= 1'b0;
      size_r     <= SZ_B;
      unsigned_r <= 1'b0;
      offset_r   <= 2'b00;
      wdata_r    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_r       <= req_we;
            size_r     <= req_size;
            unsigned_r <= req_unsigned;
            offset_r   <= req_addr[1:0];
            wdata_r    <= req_wdata;
            req_ready  <= 1'b0;
            if (req_bad) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state      <= ST_RESP;
            end else begin
              dm_addr <= {req_addr[31:2], 2'b00};
              if (req_we && req_size == SZ_W) begin
                dm_we  <= 1'b1;
                dm_din <= req_wdata;
              end
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (we_r && size_r != SZ_W) begin
            dm_din <= merge_data;
            dm_we  <= 1'b1;
            state  <= ST_WRITE;
          end else begin
            dm_we      <= 1'b0;
            resp_rdata <= we_r ? 32'h0 : load_data;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_WRITE: begin
          dm_we      <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        default: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_lsu_initiator.sv
// Self-checking bench: directed and random requests against a byte-array
// reference memory, with latency, dm_we pulse count and memory contents checked.
module tb_dm_lsu_initiator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;

  int total = 0;
  int bad   = 0;

  // Word-wide DM with async read; the backdoor port preloads contents.
  logic [31:0] mem [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = 8'h0;
  logic [31:0] bd_val = 32'h0;

  // Reference memory kept as bytes, independent of the word-lane view.
  logic [7:0]  rb [1024];

  assign dm_dout = mem[dm_addr[9:2]];

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[9:2]] <= dm_din;
    else if (bd_we) mem[bd_idx] <= bd_val;
  end

  always #5 clk = ~clk;

  dm_lsu_initiator #(.DM_DEPTH(256), .CHECK_OOR(1'b1)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .dm_addr      (dm_addr),
    .dm_we        (dm_we),
    .dm_din       (dm_din),
    .dm_dout      (dm_dout)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {rb[4*idx+3], rb[4*idx+2], rb[4*idx+1], rb[4*idx]};
  endfunction

  task automatic bd_write(input int idx, input logic [31:0] val);
    @(negedge clk);
    bd_we  = 1'b1;
    bd_idx = idx[7:0];
    bd_val = val;
    @(posedge clk);
    #1 bd_we = 1'b0;
    for (int i = 0; i < 4; i++) rb[4*idx+i] = val[8*i +: 8];
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          nbytes;
    int          a;
    int          lat;
    int          we_cnt;
    logic [31:0] got_rdata;
    logic        got_err;

    nbytes    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    exp_err   = (size == 2'b11) || (addr % nbytes != 0) || (addr >= 32'd1024);
    a         = int'(addr[9:0]);
    exp_rdata = 32'h0;
    if (!exp_err && !we) begin
      for (int i = 0; i < nbytes; i++) exp_rdata[8*i +: 8] = rb[a+i];
      if (!uns && exp_rdata[8*nbytes-1]) begin
        for (int i = nbytes; i < 4; i++) exp_rdata[8*i +: 8] = 8'hFF;
      end
    end
    exp_lat = exp_err ? 1 : (we && nbytes < 4) ? 3 : 2;

    check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata    = $urandom;
    lat = 0;
    we_cnt = 0;
    got_rdata = 32'hx;
    got_err = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (dm_we) we_cnt++;
      if (resp_valid) begin
        lat       = i;
        got_rdata = resp_rdata;
        got_err   = resp_err;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_err"}, {31'h0, got_err}, {31'h0, exp_err});
    check({tag, "_rdata"}, got_rdata, exp_rdata);
    check({tag, "_wecnt"}, we_cnt, (we && !exp_err) ? 1 : 0);
    @(negedge clk);
    check({tag, "_pulse"}, {30'h0, resp_valid, dm_we}, 32'h0);

    if (we && !exp_err) begin
      for (int i = 0; i < nbytes; i++) rb[a+i] = wdata[8*i +: 8];
      check({tag, "_mem"}, mem[a/4], ref_word(a/4));
    end
  endtask

  initial begin
    rstn         = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    #12;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_dm_addr", dm_addr, 32'h0);
    check("rst_dm_we", {31'h0, dm_we}, 32'h0);
    check("rst_dm_din", dm_din, 32'h0);

    for (int i = 0; i < 256; i++) bd_write(i, $urandom);
    @(negedge clk) rstn = 1'b1;

    bd_write(4, 32'hDEADBEEF);
    do_req("lw_10", 1'b1 ^ 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
    bd_write(4, 32'h80FF00FF);
    do_req("lb_13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    do_req("lbu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    do_req("lh_12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    do_req("lhu_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);

    bd_write(8, 32'h11223344);
    do_req("sb_21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AB);
    check("sb_21_val", mem[8], 32'h1122AB44);
    do_req("sh_22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000CAFE);
    check("sh_22_val", mem[8], 32'hCAFEAB44);
    do_req("sw_24", 1'b1, 2'b10, 1'b0, 32'h24, 32'h12345678);

    do_req("sw_06", 1'b1, 2'b10, 1'b0, 32'h06, 32'h55555555);
    do_req("lh_03", 1'b0, 2'b01, 1'b0, 32'h03, 32'h0);
    do_req("lw_400", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    do_req("sb_top", 1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h77);
    do_req("lw_3fc", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
    do_req("sz_rsv", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);

    // Reset in the WRITE cycle of a sub-word store must suppress the write.
    bd_write(8, 32'h11223344);
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h21;
    req_wdata    = 32'hAB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 check("rstw_we_before", {31'h0, dm_we}, 32'h1);
    rstn = 1'b0;
    #1 check("rstw_we_drop", {31'h0, dm_we}, 32'h0);
    check("rstw_resp", {31'h0, resp_valid}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    check("rstw_mem", mem[8], 32'h11223344);
    check("rstw_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);
    check("rstw_no_resp", {31'h0, resp_valid}, 32'h0);
    do_req("lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] addr;
      addr = ($urandom_range(0, 9) == 0) ? 32'h400 + $urandom_range(0, 255)
                                         : 32'($urandom_range(0, 255));
      do_req("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), addr, $urandom);
    end

    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_word(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
